page_table_param: RTL and testbench
===================================

PAGE_TABLE_PARAM -- requirements
Module: page_table_param

Interface
REQ-001 SHALL have parameter IDX_W, default 5, meaning page-table index width; depth = 2**IDX_W entries.
REQ-002 SHALL have parameter ENTRY_W, default 10, meaning translation payload width per entry.
REQ-003 SHALL have parameter LATENCY, default 3, meaning walk latency in cycles; legal range 1..15.
REQ-004 SHALL have port clk  input  1  the single clock; all state on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port LOOKUP_RQST  input  1  lookup request, sampled only in IDLE.
REQ-007 SHALL have port LOOKUP_ADDR  input  IDX_W  lookup index, captured with the request.
REQ-008 SHALL have port LOOKUP_COMPLETE  output  1  one-cycle pulse, result valid.
REQ-009 SHALL have port LOOKUP_RETURN  output  ENTRY_W  translation payload, valid while LOOKUP_COMPLETE=1.
REQ-010 SHALL have port LOOKUP_FAULT  output  1  entry invalid, valid while LOOKUP_COMPLETE=1.
REQ-011 SHALL have port PT_INSERT_RQST  input  1  single-cycle write strobe.
REQ-012 SHALL have port PT_INSERT_INDX  input  IDX_W  write index.
REQ-013 SHALL have port PT_INSERT_ENTRY  input  ENTRY_W  write payload; sets entry valid.
REQ-014 SHALL have port PT_FLUSH  input  1  clear all valid bits.
REQ-015 SHALL have port FAULT_CNT  output  8  saturating count of faulted lookups.

Function
REQ-016 SHALL implement FSM IDLE -> WALK -> DONE -> IDLE; WALK holds while a 4-bit down-counter is nonzero.
REQ-017 SHALL, in IDLE with LOOKUP_RQST=1 at edge k, capture LOOKUP_ADDR, load counter LATENCY-1, and enter WALK (or DONE directly when LATENCY=1).
REQ-018 SHALL assert LOOKUP_COMPLETE exactly in cycle k+LATENCY, for one cycle, then return to IDLE.
REQ-019 SHALL accept a new request in the cycle after DONE (IDLE); LOOKUP_RQST held high gives back-to-back lookups every LATENCY+1 cycles.
REQ-020 SHALL ignore LOOKUP_RQST and LOOKUP_ADDR changes outside IDLE.
REQ-021 SHALL register LOOKUP_RETURN/LOOKUP_FAULT on the edge entering DONE; both 0 when LOOKUP_COMPLETE=0.
REQ-022 SHALL accept inserts in any FSM state; the write completes at the sampling edge.
REQ-023 SHALL forward an insert to the captured index on the edge entering DONE (write-first): result = new payload, FAULT=0.
REQ-024 SHALL clear all valid bits in one cycle on PT_FLUSH; payload storage need not clear.
REQ-025 SHALL, with PT_FLUSH and PT_INSERT_RQST in the same cycle, apply flush then insert (inserted entry valid).
REQ-026 SHALL, with PT_FLUSH alone on the edge entering DONE, return FAULT=1 for that lookup.
REQ-027 SHALL increment FAULT_CNT on every DONE cycle with FAULT=1, saturating at 255.

Reset
REQ-028 SHALL, while rst=1, force FSM to IDLE, counter to 0, all valid bits to 0, FAULT_CNT to 0, and LOOKUP_COMPLETE, LOOKUP_RETURN, LOOKUP_FAULT to 0.
REQ-029 SHALL abort an in-flight walk on mid-operation reset with no COMPLETE pulse; first request is accepted on the first edge after rst falls.

Structure
REQ-030 SHALL place FSM state encoding and the LATENCY range limit in shared package pt_pkg.
REQ-031 SHALL instantiate one sub-module, pt_storage (payload array plus valid-bit vector, write port, flush, async read).

Verification
REQ-032 SHALL cover: insert idx 3 = 0x2A5, request idx 3 at edge 10 with LATENCY=3 -> COMPLETE at cycle 13, RETURN=0x2A5, FAULT=0.
REQ-033 SHALL cover: request never-written idx 7 -> FAULT=1, RETURN=0, FAULT_CNT=1; repeat 300 times -> FAULT_CNT=255.
REQ-034 SHALL cover: request idx 4, insert idx 4 = 0x111 on the edge entering DONE -> RETURN=0x111, FAULT=0.
REQ-035 SHALL cover: flush plus insert idx 2 = 0x055 same cycle, then lookups idx 2 and 3 -> 0x055 valid, idx 3 FAULT=1.
REQ-036 SHALL cover: assert rst one cycle into WALK -> no COMPLETE, outputs 0; LATENCY=1 back-to-back lookups -> COMPLETE every 2 cycles.

Source files
------------

// File: rtl/pt_pkg.sv
// ---------------------------------------------------------------------------
// pt_pkg
// Shared definitions for the page_table_param block: FSM state encoding,
// walk-latency range limits, counter widths and a helper that turns a
// walk latency into the value loaded into the walk down-counter.
// ---------------------------------------------------------------------------
package pt_pkg;

  // Lookup FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_DONE = 2'd2
  } pt_state_e;

  // Legal walk latency range; the walk counter is 4 bits wide
  localparam int unsigned LAT_MIN = 32'd1;
  localparam int unsigned LAT_MAX = 32'd15;
  localparam int unsigned CNT_W   = 32'd4;
  localparam int unsigned FCNT_W  = 32'd8;

  // Counter load value for a given latency. Out-of-range latencies are
  // clamped into [LAT_MIN, LAT_MAX] so the counter can never wrap.
  function automatic logic [CNT_W-1:0] walk_load(input int unsigned lat);
    int unsigned lat_c;
    if (lat < LAT_MIN) begin
      lat_c = LAT_MIN;
    end else if (lat > LAT_MAX) begin
      lat_c = LAT_MAX;
    end else begin
      lat_c = lat;
    end
    return CNT_W'(lat_c - 32'd1);
  endfunction

endpackage

// File: rtl/page_table_param_if.sv
// ---------------------------------------------------------------------------
// page_table_param_if
// Bundles the lookup handshake, the insert/flush write port and the fault
// counter of page_table_param.
//   master : requester side (drives lookups, inserts, flush)
//   slave  : page table side (returns COMPLETE/RETURN/FAULT and FAULT_CNT)
// ---------------------------------------------------------------------------
interface page_table_param_if
  import pt_pkg::*;
#(
  parameter int IDX_W   = 5,
  parameter int ENTRY_W = 10
);
  logic                LOOKUP_RQST;
  logic [IDX_W-1:0]    LOOKUP_ADDR;
  logic                LOOKUP_COMPLETE;
  logic [ENTRY_W-1:0]  LOOKUP_RETURN;
  logic                LOOKUP_FAULT;
  logic                PT_INSERT_RQST;
  logic [IDX_W-1:0]    PT_INSERT_INDX;
  logic [ENTRY_W-1:0]  PT_INSERT_ENTRY;
  logic                PT_FLUSH;
  logic [FCNT_W-1:0]   FAULT_CNT;

  modport master (
    output LOOKUP_RQST, LOOKUP_ADDR,
    output PT_INSERT_RQST, PT_INSERT_INDX, PT_INSERT_ENTRY, PT_FLUSH,
    input  LOOKUP_COMPLETE, LOOKUP_RETURN, LOOKUP_FAULT, FAULT_CNT
  );

  modport slave (
    input  LOOKUP_RQST, LOOKUP_ADDR,
    input  PT_INSERT_RQST, PT_INSERT_INDX, PT_INSERT_ENTRY, PT_FLUSH,
    output LOOKUP_COMPLETE, LOOKUP_RETURN, LOOKUP_FAULT, FAULT_CNT
  );
endinterface

// File: rtl/pt_storage.sv
// ---------------------------------------------------------------------------
// pt_storage
// Page-table storage: payload array plus one valid bit per entry.
//   clk, rst     : clock, asynchronous active-high reset (valid bits only)
//   wr_en_i      : write strobe; writes payload and sets the valid bit
//   wr_idx_i     : write index
//   wr_data_i    : write payload
//   flush_i      : clears every valid bit; a same-cycle write still lands
//   rd_idx_i     : asynchronous read index
//   rd_data_o    : payload at rd_idx_i
//   rd_valid_o   : valid bit at rd_idx_i
// ---------------------------------------------------------------------------
module pt_storage #(
  parameter int IDX_W   = 5,
  parameter int ENTRY_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   wr_idx_i,
  input  logic [ENTRY_W-1:0] wr_data_i,
  input  logic               flush_i,
  input  logic [IDX_W-1:0]   rd_idx_i,
  output logic [ENTRY_W-1:0] rd_data_o,
  output logic               rd_valid_o
);
  localparam int DEPTH = 1 << IDX_W;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]   valid_q;
  logic [DEPTH-1:0]   valid_d;

  // Payload array; not reset since validity is tracked separately
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end else begin
      mem_q[wr_idx_i] <= mem_q[wr_idx_i];
    end
  end

  // Next valid vector: flush first, then the insert sets its own bit
  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = {DEPTH{1'b0}};
    end else begin
      valid_d = valid_q;
    end
    if (wr_en_i) begin
      valid_d[wr_idx_i] = 1'b1;
    end else begin
      valid_d[wr_idx_i] = valid_d[wr_idx_i];
    end
  end

  // Valid-bit register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= {DEPTH{1'b0}};
    end else begin
      valid_q <= valid_d;
    end
  end

  assign rd_data_o  = mem_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];

endmodule

// File: rtl/page_table_param.sv
// ---------------------------------------------------------------------------
// page_table_param
// Fixed-latency page-table lookup. A request accepted in IDLE walks for
// LATENCY cycles and then pulses LOOKUP_COMPLETE with the payload or a
// fault. Inserts and flushes are accepted at any time; an insert to the
// index being looked up on the result edge is forwarded (write-first).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : page_table_param_if slave modport (lookup, insert, flush,
//              result and FAULT_CNT)
// ---------------------------------------------------------------------------
module page_table_param
  import pt_pkg::*;
#(
  parameter int IDX_W   = 5,
  parameter int ENTRY_W = 10,
  parameter int LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  page_table_param_if.slave     bus
);
  localparam logic [CNT_W-1:0] LOAD_VAL = walk_load(LATENCY);

  pt_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     addr_q, addr_d;

  logic                 complete_q;
  logic [ENTRY_W-1:0]   ret_q;
  logic                 fault_q;
  logic [FCNT_W-1:0]    fcnt_q;

  logic                 enter_done_s;
  logic [ENTRY_W-1:0]   rd_data_s;
  logic                 rd_valid_s;
  logic [ENTRY_W-1:0]   res_ret_s;
  logic                 res_fault_s;

  pt_storage #(
    .IDX_W   (IDX_W),
    .ENTRY_W (ENTRY_W)
  ) u_storage (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (bus.PT_INSERT_RQST),
    .wr_idx_i   (bus.PT_INSERT_INDX),
    .wr_data_i  (bus.PT_INSERT_ENTRY),
    .flush_i    (bus.PT_FLUSH),
    .rd_idx_i   (addr_d),
    .rd_data_o  (rd_data_s),
    .rd_valid_o (rd_valid_s)
  );

  // FSM next state, walk counter and captured index
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.LOOKUP_RQST) begin
          addr_d = bus.LOOKUP_ADDR;
          cnt_d  = LOAD_VAL;
          if (LOAD_VAL == {CNT_W{1'b0}}) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WALK;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WALK: begin
        // Leave on the edge where the counter reaches zero, so DONE is
        // entered LATENCY-1 edges after the accepting edge.
        cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_DONE;
        end else begin
          state_d = ST_WALK;
        end
      end
      ST_DONE: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
  end

  assign enter_done_s = (state_d == ST_DONE) && (state_q != ST_DONE);

  // Lookup result: same-edge insert wins, then flush, then stored entry
  always_comb begin
    res_ret_s   = {ENTRY_W{1'b0}};
    res_fault_s = 1'b0;
    if (bus.PT_INSERT_RQST && (bus.PT_INSERT_INDX == addr_d)) begin
      res_ret_s   = bus.PT_INSERT_ENTRY;
      res_fault_s = 1'b0;
    end else if (bus.PT_FLUSH) begin
      res_ret_s   = {ENTRY_W{1'b0}};
      res_fault_s = 1'b1;
    end else if (rd_valid_s) begin
      res_ret_s   = rd_data_s;
      res_fault_s = 1'b0;
    end else begin
      res_ret_s   = {ENTRY_W{1'b0}};
      res_fault_s = 1'b1;
    end
  end

  // FSM state, counter and captured index registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      addr_q  <= {IDX_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // Result registers; all zero outside the DONE cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      complete_q <= 1'b0;
      ret_q      <= {ENTRY_W{1'b0}};
      fault_q    <= 1'b0;
    end else if (enter_done_s) begin
      complete_q <= 1'b1;
      ret_q      <= res_ret_s;
      fault_q    <= res_fault_s;
    end else begin
      complete_q <= 1'b0;
      ret_q      <= {ENTRY_W{1'b0}};
      fault_q    <= 1'b0;
    end
  end

  // Saturating fault counter, stepped once per faulted DONE cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q <= {FCNT_W{1'b0}};
    end else if (complete_q && fault_q && (fcnt_q != {FCNT_W{1'b1}})) begin
      fcnt_q <= fcnt_q + {{(FCNT_W-1){1'b0}}, 1'b1};
    end else begin
      fcnt_q <= fcnt_q;
    end
  end

  assign bus.LOOKUP_COMPLETE = complete_q;
  assign bus.LOOKUP_RETURN   = ret_q;
  assign bus.LOOKUP_FAULT    = fault_q;
  assign bus.FAULT_CNT       = fcnt_q;

endmodule

// File: tb/tb_page_table_param.sv
// ---------------------------------------------------------------------------
// tb_page_table_param
// Directed bench: dut_a uses LATENCY=3, dut_b uses LATENCY=1. Inputs are
// driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_page_table_param;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  page_table_param_if #(.IDX_W(5), .ENTRY_W(10)) a_if ();
  page_table_param_if #(.IDX_W(5), .ENTRY_W(10)) b_if ();

  page_table_param #(.IDX_W(5), .ENTRY_W(10), .LATENCY(3)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  page_table_param #(.IDX_W(5), .ENTRY_W(10), .LATENCY(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic insert_a(input logic [4:0] idx, input logic [9:0] data, input logic flush);
    a_if.PT_INSERT_RQST  = 1'b1;
    a_if.PT_INSERT_INDX  = idx;
    a_if.PT_INSERT_ENTRY = data;
    a_if.PT_FLUSH        = flush;
    tick;
    a_if.PT_INSERT_RQST  = 1'b0;
    a_if.PT_FLUSH        = 1'b0;
  endtask

  // Full lookup on dut_a; address is scrambled during the walk and must be ignored
  task automatic lookup_a(input logic [4:0] idx, input logic chk_en,
                          output logic [9:0] ret, output logic flt);
    int n;
    a_if.LOOKUP_RQST = 1'b1;
    a_if.LOOKUP_ADDR = idx;
    tick;
    a_if.LOOKUP_RQST = 1'b0;
    a_if.LOOKUP_ADDR = ~idx;
    n = 0;
    while (!a_if.LOOKUP_COMPLETE && n < 20) begin
      tick;
      n++;
    end
    ret = a_if.LOOKUP_RETURN;
    flt = a_if.LOOKUP_FAULT;
    if (chk_en) check_eq("latency", n, 2);
    tick;
    if (chk_en) begin
      check_eq("pulse_width", a_if.LOOKUP_COMPLETE, 1'b0);
      check_eq("ret_after_done", a_if.LOOKUP_RETURN, 10'h000);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [9:0] r;
    logic       f;
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    a_if.LOOKUP_RQST = 1'b0; a_if.LOOKUP_ADDR = 5'd0;
    a_if.PT_INSERT_RQST = 1'b0; a_if.PT_INSERT_INDX = 5'd0;
    a_if.PT_INSERT_ENTRY = 10'd0; a_if.PT_FLUSH = 1'b0;
    b_if.LOOKUP_RQST = 1'b0; b_if.LOOKUP_ADDR = 5'd0;
    b_if.PT_INSERT_RQST = 1'b0; b_if.PT_INSERT_INDX = 5'd0;
    b_if.PT_INSERT_ENTRY = 10'd0; b_if.PT_FLUSH = 1'b0;
    @(negedge clk);
    tick;

    // Reset state
    check_eq("rst_complete", a_if.LOOKUP_COMPLETE, 1'b0);
    check_eq("rst_return", a_if.LOOKUP_RETURN, 10'h000);
    check_eq("rst_fault", a_if.LOOKUP_FAULT, 1'b0);
    check_eq("rst_fault_cnt", a_if.FAULT_CNT, 8'd0);
    rst = 1'b0;

    // Basic hit: idx 3 = 0x2A5
    insert_a(5'd3, 10'h2A5, 1'b0);
    lookup_a(5'd3, 1'b1, r, f);
    check_eq("hit3_ret", r, 10'h2A5);
    check_eq("hit3_fault", f, 1'b0);

    // Never-written entry faults
    lookup_a(5'd7, 1'b1, r, f);
    check_eq("miss7_ret", r, 10'h000);
    check_eq("miss7_fault", f, 1'b1);
    check_eq("miss7_cnt", a_if.FAULT_CNT, 8'd1);

    // Insert forwarded on the edge entering DONE
    a_if.LOOKUP_RQST = 1'b1;
    a_if.LOOKUP_ADDR = 5'd4;
    tick;
    a_if.LOOKUP_RQST = 1'b0;
    a_if.LOOKUP_ADDR = 5'd0;
    tick;
    check_eq("fwd_not_yet", a_if.LOOKUP_COMPLETE, 1'b0);
    insert_a(5'd4, 10'h111, 1'b0);
    check_eq("fwd_complete", a_if.LOOKUP_COMPLETE, 1'b1);
    check_eq("fwd_ret", a_if.LOOKUP_RETURN, 10'h111);
    check_eq("fwd_fault", a_if.LOOKUP_FAULT, 1'b0);
    tick;
    lookup_a(5'd4, 1'b1, r, f);
    check_eq("fwd_stored_ret", r, 10'h111);
    check_eq("fwd_stored_fault", f, 1'b0);

    // Flush and insert in the same cycle
    insert_a(5'd2, 10'h055, 1'b1);
    lookup_a(5'd2, 1'b1, r, f);
    check_eq("flins2_ret", r, 10'h055);
    check_eq("flins2_fault", f, 1'b0);
    lookup_a(5'd3, 1'b1, r, f);
    check_eq("flushed3_ret", r, 10'h000);
    check_eq("flushed3_fault", f, 1'b1);
    check_eq("flushed3_cnt", a_if.FAULT_CNT, 8'd2);

    // Flush alone on the edge entering DONE
    insert_a(5'd5, 10'h0AA, 1'b0);
    a_if.LOOKUP_RQST = 1'b1;
    a_if.LOOKUP_ADDR = 5'd5;
    tick;
    a_if.LOOKUP_RQST = 1'b0;
    tick;
    a_if.PT_FLUSH = 1'b1;
    tick;
    a_if.PT_FLUSH = 1'b0;
    check_eq("flush_done_complete", a_if.LOOKUP_COMPLETE, 1'b1);
    check_eq("flush_done_fault", a_if.LOOKUP_FAULT, 1'b1);
    check_eq("flush_done_ret", a_if.LOOKUP_RETURN, 10'h000);
    tick;
    check_eq("flush_done_cnt", a_if.FAULT_CNT, 8'd3);

    // Reset one cycle into WALK aborts the lookup
    a_if.LOOKUP_RQST = 1'b1;
    a_if.LOOKUP_ADDR = 5'd2;
    tick;
    a_if.LOOKUP_RQST = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("midrst_complete", a_if.LOOKUP_COMPLETE, 1'b0);
    check_eq("midrst_cnt", a_if.FAULT_CNT, 8'd0);
    tick;
    tick;
    check_eq("midrst_no_pulse", a_if.LOOKUP_COMPLETE, 1'b0);
    check_eq("midrst_ret", a_if.LOOKUP_RETURN, 10'h000);
    check_eq("midrst_fault", a_if.LOOKUP_FAULT, 1'b0);
    rst = 1'b0;
    lookup_a(5'd2, 1'b1, r, f);
    check_eq("postrst_fault", f, 1'b1);
    check_eq("postrst_ret", r, 10'h000);
    check_eq("postrst_cnt", a_if.FAULT_CNT, 8'd1);

    // Fault counter saturation
    for (int i = 0; i < 253; i++) lookup_a(5'd7, 1'b0, r, f);
    check_eq("cnt_254", a_if.FAULT_CNT, 8'd254);
    for (int i = 0; i < 47; i++) lookup_a(5'd7, 1'b0, r, f);
    check_eq("cnt_sat", a_if.FAULT_CNT, 8'd255);

    // LATENCY=1: held request completes every other cycle
    b_if.PT_INSERT_RQST  = 1'b1;
    b_if.PT_INSERT_INDX  = 5'd1;
    b_if.PT_INSERT_ENTRY = 10'h3FF;
    tick;
    b_if.PT_INSERT_RQST  = 1'b0;
    b_if.LOOKUP_RQST = 1'b1;
    b_if.LOOKUP_ADDR = 5'd1;
    for (int i = 0; i < 8; i++) begin
      tick;
      check_eq($sformatf("b2b_complete_%0d", i), b_if.LOOKUP_COMPLETE, (i % 2 == 0) ? 1'b1 : 1'b0);
      check_eq($sformatf("b2b_ret_%0d", i), b_if.LOOKUP_RETURN, (i % 2 == 0) ? 10'h3FF : 10'h000);
    end
    b_if.LOOKUP_RQST = 1'b0;
    check_eq("b_fault_cnt", b_if.FAULT_CNT, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
